// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the integer execute stage: funct3 opcodes and handshake FSM states.
// The optional ALU_EXEC_STAGE_ZERO_FLAG_EN feature needs nothing from this package.
package riscv_alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Encoded as {out_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational RV32/64 integer ALU: funct3/alt select among add/sub, shifts,
// compares and the bitwise operations built from gate primitives.
module alu_core
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] and_s;
  logic [XLEN-1:0] or_s;
  logic [XLEN-1:0] xor_s;
  logic [XLEN-1:0] b_op_s;
  logic [XLEN-1:0] sum_s;
  logic [XLEN-1:0] sra_s;
  logic [SHW-1:0]  shamt_s;
  logic            slt_s;
  logic            sltu_s;

  for (genvar i = 0; i < XLEN; i++) begin : g_bit
    and u_and (and_s[i], rs1[i], rs2[i]);
    or  u_or  (or_s[i],  rs1[i], rs2[i]);
    xor u_xor (xor_s[i], rs1[i], rs2[i]);
  end

  // Subtraction is rs1 + ~rs2 + 1, sharing the single adder.
  assign b_op_s  = alt ? ~rs2 : rs2;
  assign sum_s   = rs1 + b_op_s + {{(XLEN-1){1'b0}}, alt};
  assign shamt_s = rs2[SHW-1:0];
  assign sra_s   = $unsigned($signed(rs1) >>> shamt_s);
  assign slt_s   = $signed(rs1) < $signed(rs2);
  assign sltu_s  = rs1 < rs2;

  // Result selection by funct3.
  always_comb begin
    result = {XLEN{1'b0}};
    case (funct3)
      F3_ADD:  result = sum_s;
      F3_SLL:  result = rs1 << shamt_s;
      F3_SLT:  result = {{(XLEN-1){1'b0}}, slt_s};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, sltu_s};
      F3_XOR:  result = xor_s;
      F3_SR:   result = alt ? sra_s : (rs1 >> shamt_s);
      F3_OR:   result = or_s;
      F3_AND:  result = and_s;
      default: result = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: valid/ready handshake FSM, output register and one skid entry
// around alu_core. Define ALU_EXEC_STAGE_ZERO_FLAG_EN to add the registered out_zero flag.
module alu_exec_stage
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_alt,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
`ifdef ALU_EXEC_STAGE_ZERO_FLAG_EN
  ,
  output logic            out_zero
`endif
);

  state_e          state_r;
  state_e          state_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [XLEN-1:0] out_result_r;
  logic [4:0]      out_rd_r;
  logic [XLEN-1:0] skid_result_r;
  logic [4:0]      skid_rd_r;
  logic [XLEN-1:0] alu_result_s;
  logic            accept_s;
  logic            drain_s;
  logic            load_out_in_s;
  logic            load_out_skid_s;
  logic            load_skid_s;

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .funct3 (in_funct3),
    .alt    (in_alt),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .result (alu_result_s)
  );

  assign accept_s = in_valid & in_ready_r;
  assign drain_s  = out_valid_r & out_ready;

  // Next-state and datapath load selects for the handshake FSM.
  always_comb begin
    state_s         = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_s       = ST_BUSY;
          load_out_in_s = 1'b1;
        end else begin
          state_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (accept_s && drain_s) begin
          state_s       = ST_BUSY;
          load_out_in_s = 1'b1;
        end else if (accept_s) begin
          state_s     = ST_FULL;
          load_skid_s = 1'b1;
        end else if (drain_s) begin
          state_s = ST_EMPTY;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        if (drain_s) begin
          state_s         = ST_BUSY;
          load_out_skid_s = 1'b1;
        end else begin
          state_s = ST_FULL;
        end
      end
      default: state_s = ST_EMPTY;
    endcase
  end

  // State register; in_ready and out_valid are flopped from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != ST_FULL);
      out_valid_r <= (state_s != ST_EMPTY);
    end
  end

  // Output and skid data registers; output holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_r  <= {XLEN{1'b0}};
      out_rd_r      <= 5'd0;
      skid_result_r <= {XLEN{1'b0}};
      skid_rd_r     <= 5'd0;
    end else begin
      if (load_out_in_s) begin
        out_result_r <= alu_result_s;
        out_rd_r     <= in_rd;
      end else if (load_out_skid_s) begin
        out_result_r <= skid_result_r;
        out_rd_r     <= skid_rd_r;
      end else begin
        out_result_r <= out_result_r;
        out_rd_r     <= out_rd_r;
      end
      if (load_skid_s) begin
        skid_result_r <= alu_result_s;
        skid_rd_r     <= in_rd;
      end else begin
        skid_result_r <= skid_result_r;
        skid_rd_r     <= skid_rd_r;
      end
    end
  end

`ifdef ALU_EXEC_STAGE_ZERO_FLAG_EN
  logic out_zero_r;
  logic skid_zero_r;
  logic alu_zero_s;

  assign alu_zero_s = (alu_result_s == {XLEN{1'b0}});

  // Zero flag rides alongside the result through the same register path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero_r  <= 1'b0;
      skid_zero_r <= 1'b0;
    end else begin
      if (load_out_in_s) begin
        out_zero_r <= alu_zero_s;
      end else if (load_out_skid_s) begin
        out_zero_r <= skid_zero_r;
      end else begin
        out_zero_r <= out_zero_r;
      end
      if (load_skid_s) begin
        skid_zero_r <= alu_zero_s;
      end else begin
        skid_zero_r <= skid_zero_r;
      end
    end
  end

  assign out_zero = out_zero_r;
`endif

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_rd     = out_rd_r;

endmodule
